// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: state encoding, frame counter width and period bound shared by the ADC capture path
package adc_capture_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_SHIFT, ST_DONE} state_t;
    localparam int FRAME_W = 32;
    function automatic int min_period(input int dw, input int cd, input int cc, input int rh);
        return cc + 2 * cd * dw + rh + 2;
    endfunction
endpackage

// File: rtl/adc_sclk_gen.sv
// adc_sclk_gen: divided serial clock with a tick on each rising sclk edge and a pulse at the end of the last bit
module adc_sclk_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_sample_tick,
    output logic o_last_bit
);
    localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    logic [PW-1:0] r_phase;
    logic [BW-1:0] r_bits;
    logic          w_wrap;
    assign w_wrap        = i_en && r_phase == PW'(CLK_DIV - 1);
    assign o_sample_tick = w_wrap && !o_sclk;
    assign o_last_bit    = w_wrap && o_sclk && r_bits == BW'(DATA_WIDTH - 1);
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            r_phase <= '0;
            r_bits  <= '0;
            o_sclk  <= 1'b0;
        end else if (!i_en) begin
            r_phase <= '0;
            r_bits  <= '0;
            o_sclk  <= 1'b0;
        end else begin
            r_phase <= w_wrap ? '0 : r_phase + PW'(1);
            if (w_wrap) o_sclk <= !o_sclk;
            if (w_wrap && o_sclk) r_bits <= r_bits + BW'(1);
        end
endmodule

// File: rtl/adc_spi_capture.sv
// adc_spi_capture: periodically starts a CNV-triggered serial ADC, shifts in one result and presents it
// as a parallel word with a multi-cycle ready pulse.
module adc_spi_capture import adc_capture_pkg::*; #(
    parameter int DATA_WIDTH    = 16,
    parameter int CLK_DIV       = 4,
    parameter int CONV_CYCLES   = 40,
    parameter int SAMPLE_PERIOD = 200,
    parameter int RDY_HOLD      = 2
) (
    input  logic                  adc_aclk,
    input  logic                  adc_areset,
    input  logic                  enable,
    output logic                  adc_cnv,
    output logic                  adc_cs_n,
    output logic                  adc_sclk,
    input  logic                  adc_sdo,
    output logic [DATA_WIDTH-1:0] sample_data,
    output logic                  sample_rdy,
    output logic                  busy,
    output logic [FRAME_W-1:0]    frame_count
);
    localparam int PCW = $clog2(SAMPLE_PERIOD + 1);
    localparam int CCW = $clog2(CONV_CYCLES + 1);
    localparam int HW  = $clog2(RDY_HOLD + 1);
    if (SAMPLE_PERIOD < min_period(DATA_WIDTH, CLK_DIV, CONV_CYCLES, RDY_HOLD)) begin : g_period_check
        $error("SAMPLE_PERIOD %0d below minimum frame length %0d", SAMPLE_PERIOD,
               min_period(DATA_WIDTH, CLK_DIV, CONV_CYCLES, RDY_HOLD));
    end
    state_t                r_state;
    logic [PCW-1:0]        r_period;
    logic [CCW-1:0]        r_conv;
    logic [HW-1:0]         r_hold;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic [FRAME_W-1:0]    r_frame_count;
    logic                  r_cnv;
    logic                  r_cs_n;
    logic                  r_rdy;
    logic                  w_trigger;
    logic                  w_tick;
    logic                  w_last;
    assign w_trigger   = r_state == ST_IDLE && enable && r_period == '0;
    assign adc_cnv     = r_cnv;
    assign adc_cs_n    = r_cs_n;
    assign sample_data = r_data;
    assign sample_rdy  = r_rdy;
    assign frame_count = r_frame_count;
    assign busy        = r_state != ST_IDLE;
    adc_sclk_gen #(.DATA_WIDTH(DATA_WIDTH), .CLK_DIV(CLK_DIV)) u_sclk_gen (
        .i_clk        (adc_aclk),
        .i_rst        (adc_areset),
        .i_en         (r_state == ST_SHIFT),
        .o_sclk       (adc_sclk),
        .o_sample_tick(w_tick),
        .o_last_bit   (w_last)
    );
    // Held at zero while disabled so that re-enabling triggers on the very next cycle.
    always_ff @(posedge adc_aclk or posedge adc_areset)
        if (adc_areset) r_period <= '0;
        else r_period <= !enable ? '0 : w_trigger ? PCW'(SAMPLE_PERIOD - 1) :
                         r_period == '0 ? '0 : r_period - PCW'(1);
    always_ff @(posedge adc_aclk or posedge adc_areset)
        if (adc_areset) begin
            r_state       <= ST_IDLE;
            r_cnv         <= 1'b0;
            r_cs_n        <= 1'b1;
            r_rdy         <= 1'b0;
            r_conv        <= '0;
            r_hold        <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_frame_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE:
                    if (w_trigger) begin
                        r_state <= ST_CONVERT;
                        r_cnv   <= 1'b1;
                        r_conv  <= '0;
                    end
                ST_CONVERT:
                    if (r_conv == CCW'(CONV_CYCLES - 1)) begin
                        r_state <= ST_SHIFT;
                        r_cnv   <= 1'b0;
                        r_cs_n  <= 1'b0;
                    end else r_conv <= r_conv + CCW'(1);
                ST_SHIFT: begin
                    if (w_tick) r_shift <= {r_shift[DATA_WIDTH-2:0], adc_sdo};
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_cs_n  <= 1'b1;
                        r_hold  <= '0;
                    end
                end
                default: begin
                    if (r_hold == '0) begin
                        r_data        <= r_shift;
                        r_rdy         <= 1'b1;
                        r_frame_count <= r_frame_count + FRAME_W'(1);
                    end
                    if (r_hold == HW'(RDY_HOLD)) begin
                        r_rdy   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else r_hold <= r_hold + HW'(1);
                end
            endcase
        end
endmodule

// File: tb/tb_adc_spi_capture.sv
// tb_adc_spi_capture: directed vectors for the ADC capture front end, driven by an SDO model that
// presents the MSB when cs_n falls and shifts on every falling sclk edge.
module tb_adc_spi_capture;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        adc_sdo;
    logic        adc_cnv, adc_cs_n, adc_sclk, sample_rdy, busy;
    logic [15:0] sample_data;
    logic [31:0] frame_count;
    int          n_chk = 0, n_pass = 0;
    int          cyc = 0, n_cnv = 0, n_rdy = 0, n_sclk = 0, cnv_hi = 0, cs_lo = 0, rdy_hi = 0;
    int          cnv_t [16];
    int          rdy_t [16];
    logic [15:0] rd [16];
    logic [15:0] words [8] = '{16'hA5C3, 16'h0000, 16'hFFFF, 16'h8001,
                               16'h3C5A, 16'hDEAD, 16'h1234, 16'h0F0F};
    int          w_idx = 0;
    logic [15:0] r_sdo = '0;
    logic        p_cnv = 1'b0, p_rdy = 1'b0, p_sclk = 1'b0;
    int          sc0, rh0;

    adc_spi_capture #(
        .DATA_WIDTH(16), .CLK_DIV(2), .CONV_CYCLES(4), .SAMPLE_PERIOD(100), .RDY_HOLD(2)
    ) dut (
        .adc_aclk   (clk),
        .adc_areset (rst),
        .enable     (enable),
        .adc_cnv    (adc_cnv),
        .adc_cs_n   (adc_cs_n),
        .adc_sclk   (adc_sclk),
        .adc_sdo    (adc_sdo),
        .sample_data(sample_data),
        .sample_rdy (sample_rdy),
        .busy       (busy),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;
    assign adc_sdo = r_sdo[15];
    always @(posedge clk) cyc++;
    always @(negedge adc_cs_n) begin
        r_sdo = words[w_idx % 8];
        w_idx++;
    end
    always @(negedge adc_sclk) if (!adc_cs_n) r_sdo = r_sdo << 1;
    always @(negedge clk) begin
        if (adc_cnv === 1'b1 && !p_cnv) begin
            cnv_t[n_cnv % 16] = cyc;
            n_cnv++;
        end
        if (sample_rdy === 1'b1 && !p_rdy) begin
            rdy_t[n_rdy % 16] = cyc;
            rd[n_rdy % 16] = sample_data;
            n_rdy++;
        end
        if (adc_sclk === 1'b1 && !p_sclk) n_sclk++;
        if (adc_cnv === 1'b1) cnv_hi++;
        if (adc_cs_n === 1'b0) cs_lo++;
        if (sample_rdy === 1'b1) rdy_hi++;
        p_cnv  = adc_cnv === 1'b1;
        p_rdy  = sample_rdy === 1'b1;
        p_sclk = adc_sclk === 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input int n, input int lim, input string tag);
        for (int i = 0; i < lim && n_rdy < n; i++) tick(1);
        check(tag, n_rdy, n);
    endtask

    initial begin
        #2 rst = 1'b1;
        tick(3);
        check("rst_cnv", adc_cnv, 0);
        check("rst_cs_n", adc_cs_n, 1);
        check("rst_sclk", adc_sclk, 0);
        check("rst_data", sample_data, 0);
        check("rst_rdy", sample_rdy, 0);
        check("rst_busy", busy, 0);
        check("rst_fc", frame_count, 0);
        rst = 1'b0;
        tick(2);
        check("idle_cnv", adc_cnv, 0);
        // single frame
        enable = 1'b1;
        tick(1);
        check("cnv_first", adc_cnv, 1);
        wait_rdy(1, 200, "rdy1_seen");
        tick(4);
        check("cnv_high", cnv_hi, 4);
        check("sclk_pulses", n_sclk, 16);
        check("cs_low", cs_lo, 64);
        check("latency", rdy_t[0] - cnv_t[0], 69);
        check("rdy_width", rdy_hi, 2);
        check("data1", sample_data, 16'hA5C3);
        check("fc1", frame_count, 1);
        check("busy_after1", busy, 0);
        // continuous frames
        wait_rdy(4, 400, "rdy4_seen");
        tick(4);
        check("period1", cnv_t[1] - cnv_t[0], 100);
        check("period2", cnv_t[2] - cnv_t[1], 100);
        check("period3", cnv_t[3] - cnv_t[2], 100);
        check("data2", rd[1], 16'h0000);
        check("data3", rd[2], 16'hFFFF);
        check("data4", rd[3], 16'h8001);
        check("fc4", frame_count, 4);
        // enable dropped mid-shift
        for (int i = 0; i < 200 && adc_cs_n !== 1'b0; i++) tick(1);
        check("cs_fall5", adc_cs_n, 0);
        tick(10);
        enable = 1'b0;
        wait_rdy(5, 100, "rdy5_seen");
        check("data5", rd[4], 16'h3C5A);
        tick(300);
        check("no_cnv", n_cnv, 5);
        check("busy_off", busy, 0);
        check("fc5", frame_count, 5);
        // reset mid-shift
        enable = 1'b1;
        tick(1);
        check("cnv_reen", adc_cnv, 1);
        sc0 = n_sclk;
        for (int i = 0; i < 100 && n_sclk < sc0 + 7; i++) tick(1);
        check("bit7_seen", n_sclk, sc0 + 7);
        rst = 1'b1;
        #1;
        check("arst_cs_n", adc_cs_n, 1);
        check("arst_sclk", adc_sclk, 0);
        check("arst_cnv", adc_cnv, 0);
        check("arst_rdy", sample_rdy, 0);
        check("arst_fc", frame_count, 0);
        check("arst_data", sample_data, 0);
        check("arst_busy", busy, 0);
        tick(3);
        rst = 1'b0;
        wait_rdy(6, 150, "rdy6_seen");
        check("data6", rd[5], 16'h1234);
        check("fc_restart", frame_count, 1);
        // frame counter wrap
        tick(4);
        force dut.r_frame_count = 32'hFFFF_FFFF;
        tick(1);
        release dut.r_frame_count;
        tick(1);
        check("fc_preload", frame_count, 32'hFFFF_FFFF);
        rh0 = rdy_hi;
        wait_rdy(7, 150, "rdy7_seen");
        tick(4);
        check("fc_wrap", frame_count, 0);
        check("data7", sample_data, 16'h0F0F);
        check("rdy_wrap", rdy_hi - rh0, 2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
